// File: rtl/clk_div_pkg.sv
// Shared constants and types for the multi-channel clock-enable divider.
// Latency: n/a; backpressure: n/a.
package clk_div_pkg;

    localparam int DIV_W_DEFAULT   = 8;
    localparam int DEF_DIV_DEFAULT = 5;

    typedef logic [DIV_W_DEFAULT-1:0] div_t;

    // Channel-index width that stays legal for a single-channel build.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// Run-enable, divisor-write port and per-channel outputs of the divider block.
// Latency: n/a; backpressure: none, writes are fire-and-forget strobes.
interface clk_div_multi_if
    import clk_div_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int DIV_W = DIV_W_DEFAULT
);
    localparam int CH_W = ch_w(NCH);

    logic [NCH-1:0]   en;
    logic             wr_en;
    logic [CH_W-1:0]  wr_ch;
    logic [DIV_W-1:0] wr_div;
    logic [NCH-1:0]   tick;
    logic [NCH-1:0]   clk_out;
    logic [NCH-1:0]   pend;

    modport master (output en, wr_en, wr_ch, wr_div, input tick, clk_out, pend);
    modport slave  (input en, wr_en, wr_ch, wr_div, output tick, clk_out, pend);

endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/shadow divisor, tick and near-50% level.
// Latency: tick one cycle after the wrap cycle; backpressure: none, en only pauses the count.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int DIV_W   = DIV_W_DEFAULT,
    parameter int DEF_DIV = DEF_DIV_DEFAULT
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             en,
    input  logic             wr_stb,
    input  logic [DIV_W-1:0] wr_div,
    output logic             tick,
    output logic             clk_out,
    output logic             pend
);

    localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(DEF_DIV);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] act_div;
    logic [DIV_W-1:0] shd_div;
    logic [DIV_W-1:0] div_eff;
    logic [DIV_W-1:0] cnt_inc;
    logic [DIV_W:0]   half;
    logic             started;
    logic             wrap;
    logic             apply;
    logic             clk_nxt;

    always_comb begin
        div_eff = (act_div == '0) ? DIV_W'(1) : act_div;
        // >= rather than == so a divisor shrunk while paused cannot overrun the counter.
        wrap    = en && (cnt >= div_eff - DIV_W'(1));
        apply   = wrap || !en;
        cnt_inc = cnt + DIV_W'(1);
        half    = ({1'b0, div_eff} + (DIV_W+1)'(1)) >> 1;
        clk_nxt = wrap ? 1'b1 : ({1'b0, cnt_inc} < half);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt     <= '0;
            act_div <= RST_DIV;
            shd_div <= RST_DIV;
            tick    <= 1'b0;
            clk_out <= 1'b0;
            pend    <= 1'b0;
            started <= 1'b0;
        end else begin
            tick <= wrap;
            if (en) begin
                cnt <= wrap ? '0 : cnt_inc;
                if (wrap) started <= 1'b1;
                if (started || wrap) clk_out <= clk_nxt;
            end
            if (apply) act_div <= shd_div;
            // A write on an apply edge wins the pend flag so it lands at the next wrap.
            if (wr_stb) begin
                shd_div <= wr_div;
                pend    <= 1'b1;
            end else if (apply) begin
                pend    <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock-enable generator with glitch-free divisor updates.
// Latency: registered outputs; writes apply at the channel's next wrap; backpressure: none.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int DIV_W   = DIV_W_DEFAULT,
    parameter int DEF_DIV = DEF_DIV_DEFAULT
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    clk_div_multi_if.slave bus
);

    localparam int CH_W = ch_w(NCH);

    logic [NCH-1:0] tick_v;
    logic [NCH-1:0] clk_v;
    logic [NCH-1:0] pend_v;

    genvar c;
    generate
        for (c = 0; c < NCH; c++) begin : g_ch
            logic wr_stb;
            // Out-of-range channel indices match no instance and are dropped.
            assign wr_stb = bus.wr_en && (bus.wr_ch == CH_W'(c));

            clk_div_chan #(
                .DIV_W   (DIV_W),
                .DEF_DIV (DEF_DIV)
            ) u_chan (
                .sys_clk (sys_clk),
                .sys_rst (sys_rst),
                .en      (bus.en[c]),
                .wr_stb  (wr_stb),
                .wr_div  (bus.wr_div),
                .tick    (tick_v[c]),
                .clk_out (clk_v[c]),
                .pend    (pend_v[c])
            );
        end
    endgenerate

    assign bus.tick    = tick_v;
    assign bus.clk_out = clk_v;
    assign bus.pend    = pend_v;

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: tick/clk_out timing, divisor writes, pause and reset.
module tb_clk_div_multi;

    logic sys_clk = 1'b0;
    logic sys_rst;

    always #5 sys_clk = ~sys_clk;

    clk_div_multi_if #(.NCH(4), .DIV_W(8)) b4 ();
    clk_div_multi_if #(.NCH(3), .DIV_W(8)) b3 ();

    clk_div_multi #(.NCH(4), .DIV_W(8), .DEF_DIV(5)) u_dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (b4)
    );

    clk_div_multi #(.NCH(3), .DIV_W(8), .DEF_DIV(5)) u_dut3 (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (b3)
    );

    int total = 0;
    int bad   = 0;

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic do_reset();
        sys_rst   = 1'b1;
        b4.en     = '0;
        b4.wr_en  = 1'b0;
        b3.en     = '0;
        b3.wr_en  = 1'b0;
        step();
        sys_rst   = 1'b0;
    endtask

    initial begin
        sys_rst   = 1'b1;
        b4.en     = '0;
        b4.wr_en  = 1'b0;
        b4.wr_ch  = '0;
        b4.wr_div = '0;
        b3.en     = '0;
        b3.wr_en  = 1'b0;
        b3.wr_ch  = '0;
        b3.wr_div = '0;
        step();
        step();

        // Reset state
        check("rst_tick", 0, b4.tick, 0);
        check("rst_clk", 0, b4.clk_out, 0);
        check("rst_pend", 0, b4.pend, 0);
        check("rst3_tick", 0, b3.tick, 0);

        // Test 1: ch0 at default divide-by-5; 3-ch instance ignores a write to wr_ch=3
        sys_rst = 1'b0;
        b4.en   = 4'b0001;
        b3.en   = 3'b001;
        for (int k = 0; k <= 16; k++) begin
            if (k == 2) begin
                b3.wr_en = 1'b1; b3.wr_ch = 2'd3; b3.wr_div = 8'd2;
            end else begin
                b3.wr_en = 1'b0;
            end
            check("t1_tick0", k, b4.tick[0], (k > 0 && k % 5 == 0));
            check("t1_clk0", k, b4.clk_out[0], (k >= 5 && (k % 5) < 3));
            check("t1_idle", k, {b4.tick[3:1], b4.clk_out[3:1]}, 0);
            check("t1_oor_tick", k, b3.tick, (k > 0 && k % 5 == 0) ? 1 : 0);
            check("t1_oor_pend", k, b3.pend, 0);
            step();
        end

        // Test 2: ch1 5 -> 4 written in cycle 7; ch0 keeps its timing
        do_reset();
        b4.en = 4'b0011;
        for (int k = 0; k <= 23; k++) begin
            if (k == 7) begin
                b4.wr_en = 1'b1; b4.wr_ch = 2'd1; b4.wr_div = 8'd4;
            end else begin
                b4.wr_en = 1'b0;
            end
            check("t2_tick1", k, b4.tick[1], (k == 5 || k == 10 || (k >= 14 && (k - 14) % 4 == 0)));
            check("t2_pend1", k, b4.pend[1], (k == 8 || k == 9));
            check("t2_clk1", k, b4.clk_out[1],
                  (k < 5) ? 0 : (k < 10) ? ((k - 5) < 3) : (((k - 10) % 4) < 2));
            check("t2_tick0", k, b4.tick[0], (k > 0 && k % 5 == 0));
            step();
        end

        // Test 3: idle writes apply immediately; ch2 DIV=1, ch3 DIV=2
        b4.en    = 4'b0000;
        b4.wr_en = 1'b1; b4.wr_ch = 2'd2; b4.wr_div = 8'd1;
        step();
        check("t3_pend2_set", 0, b4.pend[2], 1);
        b4.wr_ch = 2'd3; b4.wr_div = 8'd2;
        step();
        check("t3_pend2_clr", 0, b4.pend[2], 0);
        check("t3_pend3_set", 0, b4.pend[3], 1);
        b4.wr_en = 1'b0;
        step();
        check("t3_pend_all", 0, b4.pend, 0);
        b4.en = 4'b1100;
        for (int k = 0; k <= 8; k++) begin
            check("t3_tick2", k, b4.tick[2], (k >= 1));
            check("t3_clk2", k, b4.clk_out[2], (k >= 1));
            check("t3_tick3", k, b4.tick[3], (k >= 2 && k % 2 == 0));
            check("t3_clk3", k, b4.clk_out[3], (k >= 2 && k % 2 == 0));
            step();
        end

        // Test 4: write 7 to ch0 during its wrap cycle (cycle 9)
        do_reset();
        b4.en = 4'b0001;
        for (int k = 0; k <= 30; k++) begin
            if (k == 9) begin
                b4.wr_en = 1'b1; b4.wr_ch = 2'd0; b4.wr_div = 8'd7;
            end else begin
                b4.wr_en = 1'b0;
            end
            check("t4_tick0", k, b4.tick[0], (k == 5 || k == 10 || k == 15 || k == 22 || k == 29));
            check("t4_pend0", k, b4.pend[0], (k >= 10 && k <= 14));
            check("t4_clk0", k, b4.clk_out[0],
                  (k < 5) ? 0 : (k < 15) ? (((k - 5) % 5) < 3) : (((k - 15) % 7) < 4));
            step();
        end

        // Test 5: en[0] low for cycles 12..14 stretches the period by 3
        do_reset();
        for (int k = 0; k <= 24; k++) begin
            b4.en = (k >= 12 && k <= 14) ? 4'b0000 : 4'b0001;
            check("t5_tick0", k, b4.tick[0], (k == 5 || k == 10 || k == 18 || k == 23));
            check("t5_clk0", k, b4.clk_out[0],
                  (k < 5)   ? 0 :
                  (k < 10)  ? ((k - 5) < 3) :
                  (k <= 15) ? 1 :
                  (k < 18)  ? 0 : (((k - 18) % 5) < 3));
            step();
        end

        // Test 6: reset mid-count with a write pending
        b4.wr_en = 1'b1; b4.wr_ch = 2'd0; b4.wr_div = 8'd3;
        step();
        b4.wr_en = 1'b0;
        check("t6_pend_before", 0, b4.pend[0], 1);
        sys_rst = 1'b1;
        step();
        sys_rst = 1'b0;
        check("t6_rst_tick", 0, b4.tick, 0);
        check("t6_rst_clk", 0, b4.clk_out, 0);
        check("t6_rst_pend", 0, b4.pend, 0);
        for (int k = 0; k <= 11; k++) begin
            check("t6_tick0", k, b4.tick[0], (k == 5 || k == 10));
            check("t6_clk0", k, b4.clk_out[0], (k >= 5 && ((k - 5) % 5) < 3));
            check("t6_pend0", k, b4.pend[0], 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
